// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin injection arbiter for one NoC router local port.
// Picks a VC per packet, tracks per-VC credits, formats head/tail/VC flits.
module noc_inject_arbiter #(
  parameter int R    = 4,
  parameter int V    = 4,
  parameter int B    = 4,
  parameter int Fpay = 32,
  localparam int Fw  = 2 + V + Fpay
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    req_valid,
  input  logic [R*Fpay-1:0] req_payload,
  input  logic [R-1:0]    req_tail,
  output logic [R-1:0]    req_ready,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  output logic            busy,
  output logic            credit_err
);

  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] CFULL = CW'(B);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [RW-1:0]         rr_ptr;
  logic [RW-1:0]         grant;
  logic [RW-1:0]         pick;
  logic                  pick_ok;
  logic [VW-1:0]         vc_sel;
  logic [VW-1:0]         vc_pick;
  logic                  vc_ok;
  logic [V-1:0][CW-1:0]  credit;
  logic                  first_flit;
  logic                  accept;
  logic                  has_credit;
  logic [V-1:0]          send_v;
  logic [V-1:0]          vc_oh;
  logic [Fpay-1:0]       payload;
  logic [RW-1:0]         rr_next;
  logic [RW:0]           sum;
  logic [RW-1:0]         idx;

  // Round-robin search from rr_ptr; descending loop lets the nearest win.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = R - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (RW+1)'(k);
      if (sum >= (RW+1)'(R))
        sum = sum - (RW+1)'(R);
      idx = sum[RW-1:0];
      if (req_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    vc_pick = '0;
    vc_ok   = 1'b0;
    for (int v = V - 1; v >= 0; v--) begin
      if (credit[v] != '0) begin
        vc_pick = VW'(v);
        vc_ok   = 1'b1;
      end
    end
  end

  assign has_credit = (credit[vc_sel] != '0);
  assign accept     = (state == SEND) & req_valid[grant] & has_credit;
  assign busy       = (state == SEND);
  assign vc_oh      = V'(1) << vc_sel;
  assign payload    = req_payload[grant*Fpay +: Fpay];
  assign rr_next    = (grant == RW'(R - 1)) ? '0 : grant + RW'(1);

  always_comb begin
    req_ready = '0;
    if (state == SEND)
      req_ready[grant] = req_valid[grant] & has_credit;
  end

  always_comb begin
    send_v         = '0;
    send_v[vc_sel] = accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      vc_sel      <= '0;
      first_flit  <= 1'b1;
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      flit_out_wr <= accept;
      if (accept)
        flit_out <= {first_flit, req_tail[grant], vc_oh, payload};
      unique case (state)
        IDLE: begin
          if (pick_ok && vc_ok) begin
            grant  <= pick;
            vc_sel <= vc_pick;
            state  <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            first_flit <= req_tail[grant];
            if (req_tail[grant]) begin
              rr_ptr <= rr_next;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A send and a returned credit on the same VC cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++)
        credit[v] <= CFULL;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        case ({send_v[v], credit_in[v]})
          2'b10: credit[v] <= credit[v] - CW'(1);
          2'b01: begin
            if (credit[v] == CFULL)
              credit_err <= 1'b1;
            else
              credit[v] <= credit[v] + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed self-checking bench for noc_inject_arbiter.
// Inputs change 1ns after posedge; checks sample there too.
module tb_noc_inject_arbiter;

  localparam int R    = 4;
  localparam int V    = 4;
  localparam int B    = 4;
  localparam int Fpay = 32;
  localparam int Fw   = 2 + V + Fpay;

  logic              clk = 1'b0;
  logic              reset;
  logic [R-1:0]      req_valid;
  logic [R*Fpay-1:0] req_payload;
  logic [R-1:0]      req_tail;
  logic [R-1:0]      req_ready;
  logic [Fw-1:0]     flit_out;
  logic              flit_out_wr;
  logic [V-1:0]      credit_in;
  logic              busy;
  logic              credit_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_inject_arbiter #(
    .R(R), .V(V), .B(B), .Fpay(Fpay)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_payload(req_payload),
    .req_tail(req_tail),
    .req_ready(req_ready),
    .flit_out(flit_out),
    .flit_out_wr(flit_out_wr),
    .credit_in(credit_in),
    .busy(busy),
    .credit_err(credit_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic h, input logic t,
                                     input logic [3:0] vc,
                                     input logic [31:0] p);
    return 64'({h, t, vc, p});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pay(input int i, input logic [31:0] p);
    req_payload[i*Fpay +: Fpay] = p;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_tail  = '0;
    credit_in = '0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_tail    = '0;
    req_payload = '0;
    credit_in   = '0;
    #1;
    tick();
    tick();
    check("rst_wr", 64'(flit_out_wr), 64'd0);
    check("rst_flit", 64'(flit_out), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(credit_err), 64'd0);
    check("rst_cred", 64'(dut.credit), 64'h924);
    check("rst_rr", 64'(dut.rr_ptr), 64'd0);
    reset = 1'b1;

    // three-flit packet from requester 0
    req_valid = 4'b0001;
    pay(0, 32'hA1);
    tick();
    check("p1_busy", 64'(busy), 64'd1);
    check("p1_ready", 64'(req_ready), 64'h1);
    tick();
    check("p1_wr1", 64'(flit_out_wr), 64'd1);
    check("p1_f1", 64'(flit_out), mk(1, 0, 4'b0001, 32'hA1));
    pay(0, 32'hA2);
    tick();
    check("p1_f2", 64'(flit_out), mk(0, 0, 4'b0001, 32'hA2));
    pay(0, 32'hA3);
    req_tail = 4'b0001;
    tick();
    check("p1_wr3", 64'(flit_out_wr), 64'd1);
    check("p1_f3", 64'(flit_out), mk(0, 1, 4'b0001, 32'hA3));
    check("p1_cred0", 64'(dut.credit[0]), 64'd1);
    check("p1_idle", 64'(busy), 64'd0);
    req_valid = '0;
    req_tail  = '0;
    tick();
    check("p1_wr_off", 64'(flit_out_wr), 64'd0);
    check("p1_hold", 64'(flit_out), mk(0, 1, 4'b0001, 32'hA3));

    // requesters 0 and 2 contend, rr_ptr=0
    do_reset();
    req_valid = 4'b0101;
    pay(0, 32'hB1);
    pay(2, 32'hC1);
    tick();
    check("rr_grant0", 64'(req_ready), 64'h1);
    tick();
    check("rr_b1", 64'(flit_out), mk(1, 0, 4'b0001, 32'hB1));
    pay(0, 32'hB2);
    req_tail = 4'b0001;
    tick();
    check("rr_b2", 64'(flit_out), mk(0, 1, 4'b0001, 32'hB2));
    check("rr_gap_busy", 64'(busy), 64'd0);
    check("rr_gap_ready", 64'(req_ready), 64'd0);
    req_valid = 4'b0100;
    req_tail  = '0;
    tick();
    check("rr_gap_wr", 64'(flit_out_wr), 64'd0);
    check("rr_grant2", 64'(req_ready), 64'h4);
    tick();
    check("rr_c1", 64'(flit_out), mk(1, 0, 4'b0001, 32'hC1));
    pay(2, 32'hC2);
    req_tail = 4'b0100;
    tick();
    check("rr_c2", 64'(flit_out), mk(0, 1, 4'b0001, 32'hC2));
    check("rr_ptr3", 64'(dut.rr_ptr), 64'd3);
    req_valid = '0;
    req_tail  = '0;

    // six flits on VC0 with only four credits
    do_reset();
    req_valid = 4'b0010;
    pay(1, 32'hD1);
    tick();
    tick();
    check("cr_d1", 64'(flit_out), mk(1, 0, 4'b0001, 32'hD1));
    pay(1, 32'hD2);
    tick();
    pay(1, 32'hD3);
    tick();
    pay(1, 32'hD4);
    tick();
    check("cr_d4", 64'(flit_out), mk(0, 0, 4'b0001, 32'hD4));
    check("cr_zero", 64'(dut.credit[0]), 64'd0);
    check("cr_stall_rdy", 64'(req_ready), 64'd0);
    pay(1, 32'hD5);
    tick();
    check("cr_stall_wr", 64'(flit_out_wr), 64'd0);
    check("cr_stall_busy", 64'(busy), 64'd1);
    credit_in = 4'b0001;
    tick();
    check("cr_ret_rdy", 64'(req_ready), 64'h2);
    check("cr_ret_wr", 64'(flit_out_wr), 64'd0);
    tick();
    check("cr_d5_wr", 64'(flit_out_wr), 64'd1);
    check("cr_d5", 64'(flit_out), mk(0, 0, 4'b0001, 32'hD5));
    check("cr_same_cyc", 64'(dut.credit[0]), 64'd1);
    credit_in = '0;
    pay(1, 32'hD6);
    req_tail = 4'b0010;
    tick();
    check("cr_d6", 64'(flit_out), mk(0, 1, 4'b0001, 32'hD6));
    check("cr_after", 64'(dut.credit[0]), 64'd0);
    check("cr_err0", 64'(credit_err), 64'd0);
    req_valid = '0;
    req_tail  = '0;
    credit_in = 4'b0010;
    tick();
    credit_in = '0;
    check("cr_err1", 64'(credit_err), 64'd1);
    check("cr_vc1_hold", 64'(dut.credit[1]), 64'd4);

    // VC0 empty: single-flit packet from req 3 goes on VC1
    req_valid = 4'b1000;
    req_tail  = 4'b1000;
    pay(3, 32'hE1);
    tick();
    check("sf_vc", 64'(dut.vc_sel), 64'd1);
    tick();
    check("sf_wr", 64'(flit_out_wr), 64'd1);
    check("sf_flit", 64'(flit_out), mk(1, 1, 4'b0010, 32'hE1));
    check("sf_rr", 64'(dut.rr_ptr), 64'd0);
    req_valid = '0;
    req_tail  = '0;
    tick();

    // reset during flit 2 of a packet
    do_reset();
    req_valid = 4'b0001;
    pay(0, 32'hF1);
    tick();
    tick();
    check("ab_f1", 64'(flit_out), mk(1, 0, 4'b0001, 32'hF1));
    pay(0, 32'hF2);
    tick();
    check("ab_f2", 64'(flit_out), mk(0, 0, 4'b0001, 32'hF2));
    reset = 1'b0;
    #1;
    check("ab_wr", 64'(flit_out_wr), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_cred", 64'(dut.credit), 64'h924);
    check("ab_err", 64'(credit_err), 64'd0);
    tick();
    reset = 1'b1;
    pay(0, 32'h61);
    tick();
    tick();
    check("ab_head", 64'(flit_out), mk(1, 0, 4'b0001, 32'h61));
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
